regfile_scan_display: RTL and testbench

Time-multiplexed display scanner that sits directly downstream of the 4×4-bit register file. It cycles the register file's read port through all four registers and captures each nibble. It then drives the matching digit of the four-digit seven-segment display with the hex pattern, so all four registers are visible at once. It owns the register file's `read_add`/`read_en` inputs and replaces the fixed single-digit enable used by the standalone display path.

---
 rtl/regfile_scan_display_if.sv | 31 +++
 rtl/regfile_scan_display.sv | 160 ++++++++++++++++
 tb/tb_regfile_scan_display.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scan_display_if.sv
// Signal bundle between the display scanner, the 4x4 register file read port
// and the four-digit seven-segment display.
interface regfile_scan_display_if;
  logic       scan_en;
  logic [3:0] rd_data;
  logic [1:0] rd_add;
  logic       rd_en;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame_done;

  modport master (
    input  scan_en,
    input  rd_data,
    output rd_add,
    output rd_en,
    output seg,
    output an,
    output frame_done
  );

  modport slave (
    output scan_en,
    output rd_data,
    input  rd_add,
    input  rd_en,
    input  seg,
    input  an,
    input  frame_done
  );
endinterface

// File: rtl/regfile_scan_display.sv
// Time-multiplexed scanner: reads each register file nibble in turn and shows it on
// its own seven-segment digit. Define REGFILE_SCAN_BLANK_EN to add BLANK_CYC dark cycles before each digit.
module regfile_scan_display #(
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned BLANK_CYC = 4
) (
  input logic                    ck,
  input logic                    rst_n,
  regfile_scan_display_if.master bus
);

  localparam int unsigned BLK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam int unsigned CNT_W = (DIV_W > BLK_W) ? DIV_W : BLK_W;
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'((64'd1 << DIV_W) - 64'd1);
`ifdef REGFILE_SCAN_BLANK_EN
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    CAPT,
    BLANK,
    SHOW
  } state_t;

  state_t           state, state_d;
  logic [1:0]       digit, digit_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [3:0]       latch, latch_d;

  logic [1:0] rd_add_d;
  logic       rd_en_d;
  logic [6:0] seg_d;
  logic [3:0] an_d;
  logic       frame_done_d;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'b0000001;
      4'h1:    hex7 = 7'b1001111;
      4'h2:    hex7 = 7'b0010010;
      4'h3:    hex7 = 7'b0000110;
      4'h4:    hex7 = 7'b1001100;
      4'h5:    hex7 = 7'b0100100;
      4'h6:    hex7 = 7'b0100000;
      4'h7:    hex7 = 7'b0001111;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0000100;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b1100000;
      4'hC:    hex7 = 7'b0110001;
      4'hD:    hex7 = 7'b1000010;
      4'hE:    hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      digit          <= '0;
      cnt            <= '0;
      latch          <= '0;
      bus.rd_add     <= '0;
      bus.rd_en      <= 1'b0;
      bus.seg        <= '1;
      bus.an         <= '1;
      bus.frame_done <= 1'b0;
    end else begin
      state          <= state_d;
      digit          <= digit_d;
      cnt            <= cnt_d;
      latch          <= latch_d;
      bus.rd_add     <= rd_add_d;
      bus.rd_en      <= rd_en_d;
      bus.seg        <= seg_d;
      bus.an         <= an_d;
      bus.frame_done <= frame_done_d;
    end
  end

  always_comb begin
    state_d = state;
    digit_d = digit;
    cnt_d   = cnt;
    latch_d = latch;

    case (state)
      IDLE: begin
        if (bus.scan_en) state_d = ADDR;
      end
      ADDR: begin
        state_d = CAPT;
      end
      CAPT: begin
        latch_d = bus.rd_data;
        cnt_d   = '0;
`ifdef REGFILE_SCAN_BLANK_EN
        state_d = BLANK;
`else
        state_d = SHOW;
`endif
      end
`ifdef REGFILE_SCAN_BLANK_EN
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
`endif
      SHOW: begin
        if (cnt == SHOW_LAST) begin
          state_d = ADDR;
          digit_d = digit + 2'd1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Disable overrides every transition; the latch deliberately survives it.
    if (!bus.scan_en) begin
      state_d = IDLE;
      digit_d = '0;
      cnt_d   = '0;
      latch_d = latch;
    end
  end

  // Outputs are registered from the next-state view so seg and an switch on the same edge.
  always_comb begin
    rd_add_d     = digit_d;
    rd_en_d      = 1'b0;
    seg_d        = '1;
    an_d         = '1;
    frame_done_d = bus.scan_en && (state == SHOW) && (cnt == SHOW_LAST) && (digit == 2'd3);

    case (state_d)
      ADDR, CAPT: begin
        rd_en_d = 1'b1;
      end
      SHOW: begin
        an_d  = ~(4'b0001 << digit_d);
        seg_d = hex7(latch_d);
      end
      default: begin
        rd_en_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_scan_display.sv
// Self-checking bench for regfile_scan_display: a frame-position reference model,
// a hex decode vector table and hand-written corner-case sequences.
`timescale 1ns/1ps
module tb_regfile_scan_display;

  localparam int unsigned DIV_W     = 2;
  localparam int unsigned BLANK_CYC = 2;
`ifdef REGFILE_SCAN_BLANK_EN
  localparam int B = BLANK_CYC;
`else
  localparam int B = 0;
`endif
  localparam int DWELL = 1 << DIV_W;
  localparam int P     = 2 + B + DWELL;
  localparam int FRAME = 4 * P;

  logic ck = 1'b0;
  logic rst_n;
  logic [3:0] regs [4];
  logic [3:0] junk;

  regfile_scan_display_if bus ();

  assign bus.rd_data = bus.rd_en ? regs[bus.rd_add] : junk;

  always #5 ck = ~ck;

  regfile_scan_display #(
    .DIV_W    (DIV_W),
    .BLANK_CYC(BLANK_CYC)
  ) dut (
    .ck   (ck),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [3:0] val;
    logic [6:0] seg;
  } vec_t;

  vec_t vecs [16];

  // Model: n = cycles since the enabling edge (-1 = idle); cap = nibble captured per digit.
  int         n;
  logic [3:0] cap [4];
  int         checks;
  int         passes;
  int         cyc;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  function automatic logic [14:0] model_out();
    int d;
    int ph;
    logic [3:0] a;
    logic [6:0] s;
    logic re;
    logic fd;
    if (n < 0) return {1'b0, 1'b0, 2'd0, 4'hF, 7'h7F};
    d  = (n / P) % 4;
    ph = n % P;
    re = (ph < 2);
    fd = (ph == 0) && (d == 0) && (n > 0);
    a  = 4'hF;
    s  = 7'h7F;
    if (ph >= 2 + B) begin
      a = ~(4'b0001 << d);
      s = vecs[cap[2'(d)]].seg;
    end
    return {fd, re, 2'(d), a, s};
  endfunction

  function automatic logic [14:0] outs();
    return {bus.frame_done, bus.rd_en, bus.rd_add, bus.an, bus.seg};
  endfunction

  task automatic tick();
    @(posedge ck);
    if (!bus.scan_en) n = -1;
    else begin
      if (n >= 0 && (n % P) == 1) cap[2'((n / P) % 4)] = regs[2'((n / P) % 4)];
      n = n + 1;
    end
    cyc++;
    @(negedge ck);
    junk = 4'($urandom);
    check("cyc", 32'(outs()), 32'(model_out()));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int         cnt [4];
    logic [6:0] segs [4];
    logic [6:0] full_exp [4];
    logic [3:0] m;
    int         t0;
    int         t1;
    int         idx;

    vecs[0]  = '{4'h0, 7'b0000001};
    vecs[1]  = '{4'h1, 7'b1001111};
    vecs[2]  = '{4'h2, 7'b0010010};
    vecs[3]  = '{4'h3, 7'b0000110};
    vecs[4]  = '{4'h4, 7'b1001100};
    vecs[5]  = '{4'h5, 7'b0100100};
    vecs[6]  = '{4'h6, 7'b0100000};
    vecs[7]  = '{4'h7, 7'b0001111};
    vecs[8]  = '{4'h8, 7'b0000000};
    vecs[9]  = '{4'h9, 7'b0000100};
    vecs[10] = '{4'hA, 7'b0001000};
    vecs[11] = '{4'hB, 7'b1100000};
    vecs[12] = '{4'hC, 7'b0110001};
    vecs[13] = '{4'hD, 7'b1000010};
    vecs[14] = '{4'hE, 7'b0110000};
    vecs[15] = '{4'hF, 7'b0111000};
    full_exp[0] = 7'b0000001;
    full_exp[1] = 7'b0100100;
    full_exp[2] = 7'b0001000;
    full_exp[3] = 7'b0111000;

    checks = 0;
    passes = 0;
    cyc    = 0;
    n      = -1;
    junk   = '0;
    for (int i = 0; i < 4; i++) begin
      regs[i] = '0;
      cap[i]  = '0;
    end
    bus.scan_en = 1'b0;
    rst_n       = 1'b0;

    // Reset, then idle with scanning disabled
    #12;
    check("reset", 32'(outs()), 32'({1'b0, 1'b0, 2'd0, 4'hF, 7'h7F}));
    @(negedge ck);
    rst_n = 1'b1;
    repeat (20) tick();

    // Hex decode table through digit 0
    for (int i = 0; i < 16; i++) begin
      bus.scan_en = 1'b0;
      tick();
      regs[0]     = vecs[i].val;
      bus.scan_en = 1'b1;
      repeat (3 + B) tick();
      check("hex_seg", 32'(bus.seg), 32'(vecs[i].seg));
      check("hex_an", 32'(bus.an), 32'(4'b1110));
    end

    // Full scan of 0,5,A,F
    bus.scan_en = 1'b0;
    tick();
    regs[0] = 4'h0;
    regs[1] = 4'h5;
    regs[2] = 4'hA;
    regs[3] = 4'hF;
    bus.scan_en = 1'b1;
    for (int d = 0; d < 4; d++) begin
      cnt[d]  = 0;
      segs[d] = 7'h7F;
    end
    repeat (FRAME) begin
      tick();
      for (int d = 0; d < 4; d++) begin
        m = ~(4'b0001 << d);
        if (bus.an == m) begin
          cnt[d]++;
          segs[d] = bus.seg;
        end
      end
    end
    for (int d = 0; d < 4; d++) begin
      check("dwell", 32'(cnt[d]), 32'(DWELL));
      check("scan_seg", 32'(segs[d]), 32'(full_exp[d]));
    end

    // frame_done spacing, bounded
    t0 = -1;
    t1 = -1;
    for (int k = 0; k < 3 * FRAME && t1 < 0; k++) begin
      tick();
      if (bus.frame_done) begin
        if (t0 < 0) t0 = cyc;
        else t1 = cyc;
      end
    end
    check("frame_period", 32'(t1 - t0), 32'(FRAME));

    // Mid-frame write of register 1 while digit 2 is shown
    repeat (2 * P + 2 + B) tick();
    check("mid_an", 32'(bus.an), 32'(4'b1011));
    regs[1] = 4'h8;
    repeat (FRAME - P) tick();
    check("mid_an1", 32'(bus.an), 32'(4'b1101));
    check("mid_seg1", 32'(bus.seg), 32'(7'b0000000));

    // Enable drop during digit 2 SHOW
    repeat (P) tick();
    check("drop_pre_an", 32'(bus.an), 32'(4'b1011));
    bus.scan_en = 1'b0;
    tick();
    check("drop_an", 32'(bus.an), 32'(4'hF));
    check("drop_rd_en", 32'(bus.rd_en), 32'(1'b0));
    bus.scan_en = 1'b1;
    tick();
    check("reen_rd", 32'({bus.rd_en, bus.rd_add}), 32'({1'b1, 2'd0}));
    repeat (2 + B) tick();
    check("reen_an", 32'(bus.an), 32'(4'b1110));
    check("reen_seg", 32'(bus.seg), 32'(7'b0000001));

    // Asynchronous reset between clock edges mid-SHOW
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_an", 32'(bus.an), 32'(4'hF));
    check("areset_seg", 32'(bus.seg), 32'(7'h7F));
    n = -1;
    for (int i = 0; i < 4; i++) cap[i] = '0;
    @(negedge ck);
    check("areset_hold", 32'(outs()), 32'(model_out()));
    rst_n = 1'b1;
    repeat (3 + B) tick();
    check("restart_an", 32'(bus.an), 32'(4'b1110));
    check("restart_seg", 32'(bus.seg), 32'(7'b0000001));

    // Random enable toggles and register writes against the model
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 39) == 0) bus.scan_en = ~bus.scan_en;
      if ($urandom_range(0, 7) == 0) begin
        idx = int'($urandom_range(0, 3));
        regs[2'(idx)] = 4'($urandom);
      end
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
